// File: rtl/sram_controller_if.sv
// CPU-side request bus of the SRAM controller: one request (write or read) held
// by the memory stage until the controller answers with ready.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [63:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Fixed-latency SRAM controller: each request holds the SRAM bus for WAIT_CYCLES
// cycles, then answers with a one-cycle DONE before accepting the next request.
module sram_controller #(
   parameter int          WAIT_CYCLES = 5,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic              clk,
   input  logic              rst,
   sram_controller_if.slave  bus,
   output logic              SRAM_WE_N,
   output logic [16:0]       SRAM_ADDR,
   inout  wire  [63:0]       SRAM_DQ,
   output logic [1:0]        state_dbg
);

   // Handshake: the requester raises wr_en or rd_en with address/write_data and
   // holds them until it sees ready=1; ready is high in IDLE with no request
   // pending or in the single DONE cycle that marks completion.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [31:0] offset;
   logic        unused_offset_bits;

   assign offset             = bus.address - BASE_ADDR;
   assign SRAM_ADDR          = offset[18:2];
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
   assign state_dbg          = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bus.ready = 1'b0;
      SRAM_WE_N = 1'b1;
      unique case (state)
         IDLE: begin
            bus.ready = !bus.wr_en && !bus.rd_en;
            // Write wins when both requests are raised together.
            if (bus.wr_en) begin
               state_n = WRITE;
               cnt_n   = '0;
            end else if (bus.rd_en) begin
               state_n = READ;
               cnt_n   = '0;
            end
         end
         READ: begin
            cnt_n = cnt + 4'd1;
            if (cnt == LAST) state_n = DONE;
         end
         WRITE: begin
            // Strobe only in the first cycle so each request is a single write edge.
            SRAM_WE_N = (cnt != 4'd0);
            cnt_n     = cnt + 4'd1;
            if (cnt == LAST) state_n = DONE;
         end
         DONE: begin
            bus.ready = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign SRAM_DQ = SRAM_WE_N ? 64'bz : {32'b0, bus.write_data};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.read_data <= '0;
      end else if (state == READ && cnt == LAST) begin
         bus.read_data <= SRAM_DQ;
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: table of single accesses plus sequences
// for reset mid-access, back-to-back requests and a long idle stretch.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        sram_we_n;
  logic [16:0] sram_addr;
  wire  [63:0] sram_dq;
  logic [1:0]  state_dbg;

  sram_controller_if bus ();

  sram_controller #(.WAIT_CYCLES(5), .BASE_ADDR(32'd1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_WE_N (sram_we_n),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq),
    .state_dbg (state_dbg)
  );

  // SRAM model: 64 words, drives the word pair whenever it is not being written.
  logic [31:0] mem [64];
  logic [5:0]  idx_lo, idx_hi;
  assign idx_lo  = sram_addr[5:0];
  assign idx_hi  = idx_lo + 6'd1;
  assign sram_dq = sram_we_n ? {mem[idx_hi], mem[idx_lo]} : 64'bz;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre_lo;
    logic [31:0] pre_hi;
    logic [16:0] exp_addr;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t        vecs [6];
  logic [63:0] exp_q [$];
  int          passed = 0;
  int          total  = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance to the sampling edge; the SRAM model latches a write on its strobe.
  task automatic tick();
    @(negedge clk);
    if (!sram_we_n) mem[sram_addr[5:0]] = sram_dq[31:0];
  endtask

  // Called just after a rising edge; returns at a falling edge.
  task automatic run_vec(input int id, input vec_t v);
    int          rdy_cyc;
    int          we_cnt;
    int          we_cyc;
    logic [63:0] dq_seen;
    logic [16:0] addr_seen;
    rdy_cyc   = -1;
    we_cnt    = 0;
    we_cyc    = -1;
    dq_seen   = '0;
    addr_seen = '0;
    if (v.rd && !v.wr) begin
      mem[v.exp_addr[5:0]]         = v.pre_lo;
      mem[v.exp_addr[5:0] + 6'd1]  = v.pre_hi;
    end
    exp_q.push_back(v.exp_rdata);
    bus.wr_en      = v.wr;
    bus.rd_en      = v.rd;
    bus.address    = v.addr;
    bus.write_data = v.wdata;
    for (int cyc = 0; cyc < 16; cyc++) begin
      tick();
      if (!sram_we_n) begin
        we_cnt++;
        we_cyc  = cyc;
        dq_seen = sram_dq;
      end
      if (cyc == 3) addr_seen = sram_addr;
      if (bus.ready) begin
        rdy_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    tick();
    check($sformatf("v%0d ready_cycle", id), 64'(rdy_cyc), 64'd6);
    check($sformatf("v%0d sram_addr", id), 64'(addr_seen), 64'(v.exp_addr));
    check($sformatf("v%0d we_pulses", id), 64'(we_cnt), v.wr ? 64'd1 : 64'd0);
    check($sformatf("v%0d ready_after", id), 64'(bus.ready), 64'd1);
    check($sformatf("v%0d read_data", id), bus.read_data, exp_q.pop_front());
    if (v.wr) begin
      check($sformatf("v%0d we_cycle", id), 64'(we_cyc), 64'd1);
      check($sformatf("v%0d dq_write", id), dq_seen, {32'b0, v.wdata});
      check($sformatf("v%0d mem_word", id), 64'(mem[v.exp_addr[5:0]]), 64'(v.wdata));
    end
  endtask

  initial begin
    vec_t        rv;
    int          err;
    logic [15:0] rdy_mask;
    logic [15:0] we_mask;

    vecs[0] = '{1'b1, 1'b0, 32'd1032, 32'h12345678, 32'h0, 32'h0, 17'h00002, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'h0, 32'h11111111, 32'h22222222, 17'h00002, 64'h22222222_11111111};
    vecs[2] = '{1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 32'h0, 32'h0, 17'h00003, 64'h22222222_11111111};
    vecs[3] = '{1'b0, 1'b1, 32'd1027, 32'h0, 32'hAAAA0000, 32'hBBBB0001, 17'h00000, 64'hBBBB0001_AAAA0000};
    vecs[4] = '{1'b1, 1'b0, 32'h000803FC, 32'hDEADBEEF, 32'h0, 32'h0, 17'h1FFFF, 64'hBBBB0001_AAAA0000};
    vecs[5] = '{1'b0, 1'b1, 32'd0, 32'h0, 32'h01234567, 32'h89ABCDEF, 17'h1FF00, 64'h89ABCDEF_01234567};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst            = 1'b0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.address    = 32'd1024;
    bus.write_data = 32'h0;

    repeat (3) tick();
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset we_n", 64'(sram_we_n), 64'd1);
    check("reset read_data", bus.read_data, 64'h0);
    check("reset state", 64'(state_dbg), 64'd0);
    rst = 1'b1;
    tick();
    check("post_reset ready", 64'(bus.ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      run_vec(i, vecs[i]);
    end

    // reset asserted in cycle 3 of a read
    @(posedge clk);
    #1;
    bus.rd_en   = 1'b1;
    bus.address = 32'd1032;
    repeat (3) tick();
    @(posedge clk);
    #3;
    rst       = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    check("midrst ready", 64'(bus.ready), 64'd1);
    check("midrst we_n", 64'(sram_we_n), 64'd1);
    check("midrst read_data", bus.read_data, 64'h0);
    check("midrst state", 64'(state_dbg), 64'd0);
    err = 0;
    repeat (4) begin
      tick();
      if (bus.read_data != 64'h0 || !sram_we_n) err++;
    end
    check("midrst hold", 64'(err), 64'd0);
    rst = 1'b1;
    rv = '{1'b0, 1'b1, 32'd1032, 32'h0, 32'h11111111, 32'hCAFEF00D, 17'h00002, 64'hCAFEF00D_11111111};
    @(posedge clk);
    #1;
    run_vec(10, rv);

    // back-to-back: write held through the cycle after DONE
    @(posedge clk);
    #1;
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1040;
    bus.write_data = 32'h0BADCAFE;
    rdy_mask = '0;
    we_mask  = '0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      tick();
      rdy_mask[cyc] = bus.ready;
      we_mask[cyc]  = !sram_we_n;
      if (cyc == 7) begin
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
      end
    end
    check("b2b ready_mask", 64'(rdy_mask), 64'h6040);
    check("b2b we_mask", 64'(we_mask), 64'h0102);
    check("b2b mem_word", 64'(mem[4]), 64'h0BADCAFE);
    check("b2b read_data", bus.read_data, 64'hCAFEF00D_11111111);

    // idle: the bus must carry only what the SRAM model drives
    bus.address    = 32'd1024;
    bus.write_data = 32'hFFFFFFFF;
    mem[0]         = 32'h0;
    mem[1]         = 32'h55555555;
    err = 0;
    begin
      int we_err;
      int dq_err;
      we_err = 0;
      dq_err = 0;
      repeat (20) begin
        tick();
        if (!bus.ready) err++;
        if (!sram_we_n) we_err++;
        if (sram_dq !== 64'h55555555_00000000) dq_err++;
      end
      check("idle ready", 64'(err), 64'd0);
      check("idle we_n", 64'(we_err), 64'd0);
      check("idle dq", 64'(dq_err), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 5: number of clock cycles the SRAM bus is held per access. Legal range is 1 to 15.
REQ-002 SHALL have parameter BASE_ADDR, default 32'd1024: CPU byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 wr_en  input  1  write request from the memory stage; held until ready.
REQ-006 rd_en  input  1  read request from the memory stage; held until ready.
REQ-007 address  input  32  CPU byte address.
REQ-008 write_data  input  32  write data.
REQ-009 read_data  output  64  registered pair {word[2n+1], word[2n]}.
REQ-010 ready  output  1  high means the controller can accept a request or has completed one; low means stall the pipeline.
REQ-011 SRAM_WE_N  output  1  SRAM write strobe, active-low.
REQ-012 SRAM_ADDR  output  17  SRAM word address.
REQ-013 SRAM_DQ  inout  64  SRAM data bus.

Function
REQ-014 SHALL form SRAM_ADDR as bits [18:2] of (address - BASE_ADDR), computed with 32-bit wrap-around subtraction. Byte offset bits [1:0] are ignored.
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE plus a 4-bit wait counter cnt.
REQ-016 In IDLE: wr_en=1 goes to WRITE; else rd_en=1 goes to READ; else stay in IDLE. cnt is cleared on entry to READ or WRITE.
REQ-017 When wr_en and rd_en are both 1, the write SHALL take priority and the read SHALL be ignored.
REQ-018 READ/WRITE: cnt increments each cycle. When cnt==WAIT_CYCLES-1, the next state is DONE.
REQ-019 DONE SHALL last exactly one cycle and then go unconditionally to IDLE.
REQ-020 ready SHALL be combinational: ready = (IDLE and !wr_en and !rd_en) or DONE. It is 0 in READ and WRITE, and 0 in IDLE while a request is present.
REQ-021 Latency: a request first seen in IDLE in cycle 0 gives ready=1 in cycle WAIT_CYCLES+1 (cycle 6 with the default).
REQ-022 SRAM_WE_N SHALL be 0 only in the WRITE cycle where cnt==0, so each request produces exactly one SRAM write edge. It is 1 in every other state and cycle.
REQ-023 SRAM_DQ SHALL be driven with {32'b0, write_data} only while SRAM_WE_N=0. Otherwise it is high-impedance (64'bz).
REQ-024 SRAM_ADDR SHALL reflect address combinationally in every state. The requester holds address stable from request until ready.
REQ-025 read_data SHALL capture SRAM_DQ on the clock edge leaving READ (cnt==WAIT_CYCLES-1), and SHALL hold that value until the next read completes. Writes never change read_data.
REQ-026 If a request is still held in IDLE after DONE, it SHALL start a new access. The requester drops the request in the cycle after it sees ready.
REQ-027 Any change of request or address mid-access SHALL NOT abort the access. The FSM completes using the current address.

Reset
REQ-028 Reset asserted (rst=0) SHALL immediately, without waiting for a clock edge, force: state=IDLE, cnt=0, read_data=64'b0, SRAM_WE_N=1, SRAM_DQ=high-impedance.
REQ-029 Reset asserted during READ or WRITE SHALL abandon the access. No partial read_data update and no SRAM_WE_N pulse may occur after reset is asserted.
REQ-030 After reset is released, the first rising edge SHALL evaluate IDLE transitions normally.

Verification
REQ-031 Write: wr_en=1, address=1032, write_data=32'h12345678 -> SRAM_ADDR=2; SRAM_WE_N=0 in cycle 1 only; SRAM_DQ=64'h0000000012345678 in that cycle; ready=1 in cycle 6; SRAM word 2 = 32'h12345678.
REQ-032 Read: SRAM words 2=32'h11111111 and 3=32'h22222222, rd_en=1, address=1032 -> ready=0 in cycles 0-5, ready=1 in cycle 6, read_data=64'h2222222211111111 from cycle 6 onward; SRAM_WE_N stays 1.
REQ-033 Simultaneous request: wr_en=1 and rd_en=1 at address 1036 -> WRITE path taken; read_data unchanged; exactly one SRAM_WE_N low cycle.
REQ-034 Reset mid-operation: rst=0 in cycle 3 of a read -> ready and SRAM_WE_N settle at 1 (no request present) and read_data=0 before the next edge; a new read after release completes in 6 cycles.
REQ-035 Back-to-back: request held one cycle past DONE -> a second access starts and gives a second ready pulse 7 cycles after the first.
REQ-036 Idle: no requests for 20 cycles -> ready=1, SRAM_WE_N=1 and SRAM_DQ high-impedance throughout.
